// File: rtl/fulladder32_sync.sv
// Registered ripple-carry adder: S/Pout/Ovf capture A + B + Pin one clock later.

// One-bit full-adder cell, the link of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority carry for a single bit position.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

module fulladder32_sync #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Pin,
  output logic [WIDTH-1:0] S,
  output logic             Pout,
  output logic             Ovf
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s_next;
  logic             pout_next;
  logic             ovf_next;

  assign carry[0] = Pin;

  // Carry ripples from cell 0 up to cell WIDTH-1.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (s_next[i]),
      .co (carry[i+1])
    );
  end

  // Carry-out and two's-complement overflow of the combinational sum.
  always_comb begin
    pout_next = carry[WIDTH];
    ovf_next  = (A[MSB] ~^ B[MSB]) & (s_next[MSB] ^ A[MSB]);
  end

  // Output register; reset discards the result in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S    <= '0;
      Pout <= 1'b0;
      Ovf  <= 1'b0;
    end else begin
      S    <= s_next;
      Pout <= pout_next;
      Ovf  <= ovf_next;
    end
  end

endmodule

// File: tb/tb_fulladder32_sync.sv
// Scoreboard bench for fulladder32_sync: driver queues expected results, monitor compares.
module tb_fulladder32_sync;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic        Pin;
  logic [31:0] S;
  logic        Pout;
  logic        Ovf;

  typedef struct {
    logic [31:0] s;
    logic        pout;
    logic        ovf;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;
  bit   stop_mon;

  fulladder32_sync #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Pin   (Pin),
    .S     (S),
    .Pout  (Pout),
    .Ovf   (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic, unsigned for S/Pout, signed range test for Ovf.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic pin, input logic rst, input string tag);
    exp_t    e;
    longint  usum;
    longint  ssum;
    usum = longint'(a) + longint'(b) + longint'(pin);
    ssum = longint'($signed(a)) + longint'($signed(b)) + longint'(pin);
    e.tag = tag;
    if (!rst) begin
      e.s    = 32'h0;
      e.pout = 1'b0;
      e.ovf  = 1'b0;
    end else begin
      e.s    = 32'(usum % 64'sd4294967296);
      e.pout = (usum >= 64'sd4294967296);
      e.ovf  = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
    end
    return e;
  endfunction

  // Apply one vector before the next rising edge and queue its expected result.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic pin,
                       input logic rst, input string tag);
    @(negedge clk);
    A     = a;
    B     = b;
    Pin   = pin;
    rst_n = rst;
    q.push_back(model(a, b, pin, rst, tag));
  endtask

  // Compare the DUT outputs after every rising edge against the oldest queued entry.
  task automatic monitor();
    exp_t e;
    while (!stop_mon) begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (S !== e.s || Pout !== e.pout || Ovf !== e.ovf) begin
          errors++;
          $display("FAIL %s: got S=%h Pout=%b Ovf=%b, want S=%h Pout=%b Ovf=%b",
                   e.tag, S, Pout, Ovf, e.s, e.pout, e.ovf);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] one_k;
    logic        rp;
    logic        rr;

    checks   = 0;
    errors   = 0;
    stop_mon = 1'b0;
    rst_n    = 1'b0;
    A        = 32'd5;
    B        = 32'd7;
    Pin      = 1'b1;

    fork
      monitor();
    join_none

    // Reset held two cycles with live operands, then released.
    drive(32'd5, 32'd7, 1'b1, 1'b0, "reset0");
    drive(32'd5, 32'd7, 1'b1, 1'b0, "reset1");
    drive(32'd5, 32'd7, 1'b1, 1'b1, "release");

    // Directed small sums.
    drive(32'd0,     32'd0,     1'b0, 1'b1, "d_0_0");
    drive(32'd1,     32'd0,     1'b0, 1'b1, "d_1_0");
    drive(32'd50,    32'd20,    1'b0, 1'b1, "d_50_20");
    drive(32'd0,     32'd100,   1'b0, 1'b1, "d_0_100");
    drive(32'd1995,  32'd1996,  1'b1, 1'b1, "d_1995_1996");
    drive(32'd10,    32'd100,   1'b0, 1'b1, "d_10_100");
    drive(32'd40067, 32'd73469, 1'b1, 1'b1, "d_40067_73469");
    drive(32'd43678, 32'd1331,  1'b0, 1'b1, "d_43678_1331");

    // Carry/wrap and signed overflow corners.
    drive(32'hFFFF_FFFF, 32'h0,         1'b1, 1'b1, "wrap_carry_in");
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, "wrap_all_ones");
    drive(32'h7FFF_FFFF, 32'h1,         1'b0, 1'b1, "ovf_pos");
    drive(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, "ovf_neg");

    // Carry-chain walk, one bit position at a time.
    drive(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, "walk_full");
    for (int k = 0; k < 32; k++) begin
      one_k = 32'h1 << k;
      drive(one_k, one_k, 1'b0, 1'b1, $sformatf("walk_%0d", k));
    end

    // Random stream with occasional single-cycle resets.
    for (int n = 0; n < 10000; n++) begin
      ra = $urandom();
      rb = $urandom();
      rp = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 99) != 0);
      drive(ra, rb, rp, rr, $sformatf("rand_%0d", n));
    end

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    stop_mon = 1'b1;
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never observed, want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
